// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by an internal word-addressed memory; one write burst and one read burst in flight, independently.
// Optional macro AXI_RSP_RANGE_CHECK_EN: beats beyond MEM_WORDS*NB bytes get DECERR instead of aliasing.
module axi_mem_responder #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_WORDS      = 2048
) (
    input  logic                        clk,
    input  logic                        rst_n,
    // write address
    input  logic                        aw_valid,
    output logic                        aw_ready,
    input  logic [AXI_ID_WIDTH-1:0]     aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
    input  logic [7:0]                  aw_len,
    input  logic [2:0]                  aw_size,
    input  logic [1:0]                  aw_burst,
    // write data
    input  logic                        w_valid,
    input  logic [AXI_DATA_WIDTH-1:0]   w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
    input  logic                        w_last,
    output logic                        w_ready,
    // write response
    output logic                        b_valid,
    output logic [AXI_ID_WIDTH-1:0]     b_id,
    output logic [1:0]                  b_resp,
    input  logic                        b_ready,
    // read address
    input  logic                        ar_valid,
    output logic                        ar_ready,
    input  logic [AXI_ID_WIDTH-1:0]     ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
    input  logic [7:0]                  ar_len,
    input  logic [2:0]                  ar_size,
    input  logic [1:0]                  ar_burst,
    // read data
    output logic                        r_valid,
    output logic [AXI_ID_WIDTH-1:0]     r_id,
    output logic [AXI_DATA_WIDTH-1:0]   r_data,
    output logic [1:0]                  r_resp,
    output logic                        r_last,
    input  logic                        r_ready
);

    localparam int NB       = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int MEM_AW   = $clog2(MEM_WORDS);
    localparam logic [2:0] SIZE_MAX = 3'(ADDR_LSB);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_ONE = {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;

    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(
        input logic [AXI_ADDR_WIDTH-1:0] addr,
        input logic [2:0]                size,
        input logic [7:0]                len,
        input logic [1:0]                burst
    );
        logic [AXI_ADDR_WIDTH-1:0] step;
        logic [AXI_ADDR_WIDTH-1:0] incr;
        logic [AXI_ADDR_WIDTH-1:0] mask;
        step = ADDR_ONE << size;
        incr = addr + step;
        mask = ((({{(AXI_ADDR_WIDTH-8){1'b0}}, len}) + ADDR_ONE) << size) - ADDR_ONE;
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~mask) | (incr & mask);
            default: next_addr = incr;
        endcase
    endfunction

    function automatic logic burst_illegal(
        input logic [7:0] len,
        input logic [2:0] size,
        input logic [1:0] burst
    );
        logic bad_wrap;
        bad_wrap = (burst == 2'b10) &&
                   !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        burst_illegal = (burst == 2'b11) || (size > SIZE_MAX) || bad_wrap;
    endfunction

    // Ready outputs stay low until the first clock after reset release.
    logic active_reg;

    // ---------------- write channel ----------------
    wr_state_t                 wr_state_reg, wr_state_next;
    logic [AXI_ID_WIDTH-1:0]   wr_id_reg;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_reg;
    logic [7:0]                wr_len_reg;
    logic [7:0]                wr_beat_reg;
    logic [2:0]                wr_size_reg;
    logic [1:0]                wr_burst_reg;
    logic                      wr_illegal_reg;
    logic                      wr_slverr_reg;
    logic                      wr_decerr_reg;
    logic                      aw_fire, w_fire, wr_last_beat, wr_oor, wr_en;
    logic [MEM_AW-1:0]         wr_idx;

    // ---------------- read channel ----------------
    rd_state_t                 rd_state_reg, rd_state_next;
    logic [AXI_ID_WIDTH-1:0]   rd_id_reg;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr_reg;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr_next;
    logic [7:0]                rd_len_reg;
    logic [7:0]                rd_beat_reg;
    logic [2:0]                rd_size_reg;
    logic [1:0]                rd_burst_reg;
    logic                      rd_illegal_reg;
    logic [AXI_DATA_WIDTH-1:0] r_data_reg;
    logic [1:0]                r_resp_reg;
    logic                      r_last_reg;
    logic                      ar_fire, r_fire, rd_oor, rd_mem_en;
    logic [MEM_AW-1:0]         rd_idx;
    logic [AXI_DATA_WIDTH-1:0] mem_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg   <= 1'b0;
            wr_state_reg <= W_IDLE;
            rd_state_reg <= R_IDLE;
        end else begin
            active_reg   <= 1'b1;
            wr_state_reg <= wr_state_next;
            rd_state_reg <= rd_state_next;
        end
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        aw_ready      = 1'b0;
        w_ready       = 1'b0;
        b_valid       = 1'b0;
        case (wr_state_reg)
            W_IDLE: begin
                aw_ready = active_reg;
                if (aw_valid && active_reg) wr_state_next = W_DATA;
            end
            W_DATA: begin
                w_ready = 1'b1;
                if (w_valid && wr_last_beat) wr_state_next = W_RESP;
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (b_ready) wr_state_next = W_IDLE;
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    assign aw_fire      = aw_valid && aw_ready;
    assign w_fire       = w_valid && w_ready;
    assign wr_last_beat = (wr_beat_reg == wr_len_reg);
    assign wr_idx       = wr_addr_reg[ADDR_LSB +: MEM_AW];
    assign wr_en        = w_fire && !wr_illegal_reg && !wr_oor;

`ifdef AXI_RSP_RANGE_CHECK_EN
    assign wr_oor = |wr_addr_reg[AXI_ADDR_WIDTH-1:ADDR_LSB+MEM_AW];
    assign rd_oor = |rd_addr_reg[AXI_ADDR_WIDTH-1:ADDR_LSB+MEM_AW];
`else
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
`endif

    // The beat counter alone ends the burst; a misplaced w_last only flags SLVERR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_id_reg      <= '0;
            wr_addr_reg    <= '0;
            wr_len_reg     <= '0;
            wr_beat_reg    <= '0;
            wr_size_reg    <= '0;
            wr_burst_reg   <= '0;
            wr_illegal_reg <= 1'b0;
            wr_slverr_reg  <= 1'b0;
            wr_decerr_reg  <= 1'b0;
        end else if (aw_fire) begin
            wr_id_reg      <= aw_id;
            wr_addr_reg    <= aw_addr;
            wr_len_reg     <= aw_len;
            wr_beat_reg    <= '0;
            wr_size_reg    <= aw_size;
            wr_burst_reg   <= aw_burst;
            wr_illegal_reg <= burst_illegal(aw_len, aw_size, aw_burst);
            wr_slverr_reg  <= burst_illegal(aw_len, aw_size, aw_burst);
            wr_decerr_reg  <= 1'b0;
        end else if (w_fire) begin
            wr_addr_reg <= next_addr(wr_addr_reg, wr_size_reg, wr_len_reg, wr_burst_reg);
            wr_beat_reg <= wr_beat_reg + 8'd1;
            if (w_last != wr_last_beat) wr_slverr_reg <= 1'b1;
            if (wr_oor)                 wr_decerr_reg <= 1'b1;
        end
    end

    assign b_id   = wr_id_reg;
    assign b_resp = !b_valid      ? 2'b00 :
                    wr_decerr_reg ? 2'b11 :
                    wr_slverr_reg ? 2'b10 : 2'b00;

    always_comb begin
        rd_state_next = rd_state_reg;
        ar_ready      = 1'b0;
        r_valid       = 1'b0;
        case (rd_state_reg)
            R_IDLE: begin
                ar_ready = active_reg;
                if (ar_valid && active_reg) rd_state_next = R_FETCH;
            end
            R_FETCH: rd_state_next = R_DATA;
            R_DATA: begin
                r_valid = 1'b1;
                if (r_ready) rd_state_next = r_last_reg ? R_IDLE : R_FETCH;
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    assign ar_fire      = ar_valid && ar_ready;
    assign r_fire       = r_valid && r_ready;
    assign rd_addr_next = next_addr(rd_addr_reg, rd_size_reg, rd_len_reg, rd_burst_reg);
    assign rd_idx       = (rd_state_reg == R_IDLE) ? ar_addr[ADDR_LSB +: MEM_AW]
                                                   : rd_addr_next[ADDR_LSB +: MEM_AW];
    assign rd_mem_en    = ar_fire || (r_fire && !r_last_reg);

    // RAM output is captured into r_data in R_FETCH so it stays stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_id_reg      <= '0;
            rd_addr_reg    <= '0;
            rd_len_reg     <= '0;
            rd_beat_reg    <= '0;
            rd_size_reg    <= '0;
            rd_burst_reg   <= '0;
            rd_illegal_reg <= 1'b0;
            r_data_reg     <= '0;
            r_resp_reg     <= 2'b00;
            r_last_reg     <= 1'b0;
        end else begin
            if (ar_fire) begin
                rd_id_reg      <= ar_id;
                rd_addr_reg    <= ar_addr;
                rd_len_reg     <= ar_len;
                rd_beat_reg    <= '0;
                rd_size_reg    <= ar_size;
                rd_burst_reg   <= ar_burst;
                rd_illegal_reg <= burst_illegal(ar_len, ar_size, ar_burst);
            end else if (r_fire && !r_last_reg) begin
                rd_addr_reg <= rd_addr_next;
                rd_beat_reg <= rd_beat_reg + 8'd1;
            end
            if (rd_state_reg == R_FETCH) begin
                r_data_reg <= (rd_illegal_reg || rd_oor) ? '0 : mem_rd_data;
                r_resp_reg <= rd_oor ? 2'b11 : (rd_illegal_reg ? 2'b10 : 2'b00);
                r_last_reg <= (rd_beat_reg == rd_len_reg);
            end
        end
    end

    assign r_id   = rd_id_reg;
    assign r_data = r_data_reg;
    assign r_resp = r_resp_reg;
    assign r_last = r_last_reg;

    // One byte-wide RAM per lane; read-before-write gives old data on a same-word collision.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] lane_mem [MEM_WORDS];
        logic [7:0] rd_byte_reg;

        always_ff @(posedge clk) begin
            if (wr_en && w_strb[gi]) lane_mem[wr_idx] <= w_data[gi*8 +: 8];
            if (rd_mem_en)           rd_byte_reg      <= lane_mem[rd_idx];
        end

        assign mem_rd_data[gi*8 +: 8] = rd_byte_reg;
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: write bursts, a table of read bursts, and backpressure/reset sequences.
module tb_axi_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aw_valid = 1'b0, aw_ready;
    logic [3:0]  aw_id = '0;
    logic [31:0] aw_addr = '0;
    logic [7:0]  aw_len = '0;
    logic [2:0]  aw_size = '0;
    logic [1:0]  aw_burst = '0;
    logic        w_valid = 1'b0, w_last = 1'b0, w_ready;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        b_valid, b_ready = 1'b0;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_valid = 1'b0, ar_ready;
    logic [3:0]  ar_id = '0;
    logic [31:0] ar_addr = '0;
    logic [7:0]  ar_len = '0;
    logic [2:0]  ar_size = '0;
    logic [1:0]  ar_burst = '0;
    logic        r_valid, r_last, r_ready = 1'b0;
    logic [3:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;

    axi_mem_responder #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .MEM_WORDS(2048)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_ready(w_ready),
        .b_valid(b_valid), .b_id(b_id), .b_resp(b_resp), .b_ready(b_ready),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .r_ready(r_ready)
    );

    always #5 clk = ~clk;

`ifdef AXI_RSP_RANGE_CHECK_EN
    localparam logic [63:0] OOR_DATA = 64'h0;
    localparam logic [1:0]  OOR_RESP = 2'b11;
`else
    localparam logic [63:0] OOR_DATA = 64'h77;
    localparam logic [1:0]  OOR_RESP = 2'b00;
`endif

    typedef struct {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0][63:0] exp;
        logic [1:0]       resp;
    } rd_vec_t;

    rd_vec_t vecs [11];

    int checks = 0;
    int errors = 0;

    logic [63:0] got_data [16];
    logic [1:0]  got_resp [16];
    logic        got_last [16];
    logic [3:0]  got_id   [16];
    int          got_lat  [16];
    int          got_n;

    function automatic rd_vec_t mk(input logic [31:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst,
                                   input logic [63:0] e0, input logic [63:0] e1,
                                   input logic [63:0] e2, input logic [63:0] e3,
                                   input logic [1:0] resp);
        rd_vec_t v;
        v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        v.resp = resp;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string what);
        checks++;
        errors++;
        $display("FAIL timeout %s: got no handshake, expected one within 50 cycles", what);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input logic [3:0][63:0] data,
                            input logic [7:0] strb, input logic [3:0] last_mask, input int bstall,
                            output logic [1:0] resp, output logic [3:0] bid);
        int n;
        resp = 2'bxx;
        bid  = 4'bxxxx;
        @(negedge clk);
        aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = 3'd3; aw_burst = burst;
        n = 0;
        while (!aw_ready && n < 50) begin @(negedge clk); n++; end
        if (!aw_ready) begin aw_valid = 1'b0; timeout_fail("aw_ready"); return; end
        @(negedge clk);
        aw_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            w_valid = 1'b1; w_data = data[i]; w_strb = strb; w_last = last_mask[i];
            n = 0;
            while (!w_ready && n < 50) begin @(negedge clk); n++; end
            if (!w_ready) begin w_valid = 1'b0; timeout_fail("w_ready"); return; end
            @(negedge clk);
        end
        w_valid = 1'b0; w_last = 1'b0;
        n = 0;
        while (!b_valid && n < 50) begin @(negedge clk); n++; end
        if (!b_valid) begin timeout_fail("b_valid"); return; end
        for (int s = 0; s < bstall; s++) begin
            check("b_valid_held", 64'(b_valid), 64'd1);
            check("aw_ready_busy", 64'(aw_ready), 64'd0);
            @(negedge clk);
        end
        resp = b_resp;
        bid  = b_id;
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int stall_beat,
                           input int stall_cycles, input logic [63:0] stall_data, input logic stall_last);
        int n;
        got_n = 0;
        @(negedge clk);
        ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
        n = 0;
        while (!ar_ready && n < 50) begin @(negedge clk); n++; end
        if (!ar_ready) begin ar_valid = 1'b0; timeout_fail("ar_ready"); return; end
        @(negedge clk);
        ar_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            r_ready = (i != stall_beat);
            n = 0;
            while (!r_valid && n < 50) begin @(negedge clk); n++; end
            if (!r_valid) begin r_ready = 1'b0; timeout_fail("r_valid"); return; end
            got_lat[i] = n;
            if (i == stall_beat) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    check("stall_r_valid", 64'(r_valid), 64'd1);
                    check("stall_r_data", r_data, stall_data);
                    check("stall_r_last", 64'(r_last), 64'(stall_last));
                    @(negedge clk);
                end
                r_ready = 1'b1;
            end
            got_data[i] = r_data;
            got_resp[i] = r_resp;
            got_last[i] = r_last;
            got_id[i]   = r_id;
            got_n++;
            @(negedge clk);
        end
        r_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200 us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][63:0] wd;
        logic [1:0]       resp;
        logic [3:0]       bid;

        // Memory state when the table runs: 0x100..0x118 = 11,22,33,44; 0x200 = AA,BB;
        // 0x300 = CC,DD; word 0 = 77. Illegal bursts read 0 with SLVERR.
        vecs[0]  = mk(32'h100,  8'd3, 3'd3, 2'b01, 64'h11, 64'h22, 64'h33, 64'h44, 2'b00);
        vecs[1]  = mk(32'h118,  8'd3, 3'd3, 2'b10, 64'h44, 64'h11, 64'h22, 64'h33, 2'b00);
        vecs[2]  = mk(32'h108,  8'd2, 3'd3, 2'b00, 64'h22, 64'h22, 64'h22, 64'h0,  2'b00);
        vecs[3]  = mk(32'h200,  8'd1, 3'd3, 2'b01, 64'hAA, 64'hBB, 64'h0,  64'h0,  2'b00);
        vecs[4]  = mk(32'h300,  8'd1, 3'd3, 2'b01, 64'hCC, 64'hDD, 64'h0,  64'h0,  2'b00);
        vecs[5]  = mk(32'h100,  8'd2, 3'd3, 2'b10, 64'h0,  64'h0,  64'h0,  64'h0,  2'b10);
        vecs[6]  = mk(32'h100,  8'd0, 3'd4, 2'b01, 64'h0,  64'h0,  64'h0,  64'h0,  2'b10);
        vecs[7]  = mk(32'h100,  8'd1, 3'd3, 2'b11, 64'h0,  64'h0,  64'h0,  64'h0,  2'b10);
        vecs[8]  = mk(32'h4000, 8'd0, 3'd3, 2'b01, OOR_DATA, 64'h0, 64'h0, 64'h0, OOR_RESP);
        vecs[9]  = mk(32'h10C,  8'd3, 3'd2, 2'b10, 64'h22, 64'h11, 64'h11, 64'h22, 2'b00);
        vecs[10] = mk(32'h104,  8'd2, 3'd2, 2'b01, 64'h11, 64'h22, 64'h22, 64'h0,  2'b00);

        // Reset state
        #12;
        check("rst_aw_ready", 64'(aw_ready), 64'd0);
        check("rst_w_ready",  64'(w_ready),  64'd0);
        check("rst_b_valid",  64'(b_valid),  64'd0);
        check("rst_ar_ready", 64'(ar_ready), 64'd0);
        check("rst_r_valid",  64'(r_valid),  64'd0);
        check("rst_b_resp",   64'(b_resp),   64'd0);
        check("rst_r_resp",   64'(r_resp),   64'd0);
        check("rst_r_data",   r_data,        64'd0);
        check("rst_r_last",   64'(r_last),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write bursts
        wd = {64'h44, 64'h33, 64'h22, 64'h11};
        do_write(32'h100, 8'd3, 2'b01, 4'd3, wd, 8'hFF, 4'b1000, 0, resp, bid);
        check("w_incr_resp", 64'(resp), 64'd0);
        check("w_incr_bid",  64'(bid),  64'd3);
        $display("write addr=100 len=3 incr resp=%0b id=%0d", resp, bid);

        wd = {64'h0, 64'h0, 64'hBB, 64'hAA};
        do_write(32'h200, 8'd1, 2'b01, 4'd5, wd, 8'hFF, 4'b0001, 0, resp, bid);
        check("w_early_last_resp", 64'(resp), 64'd2);
        check("w_early_last_bid",  64'(bid),  64'd5);
        $display("write addr=200 len=1 early w_last resp=%0b", resp);

        wd = {64'h0, 64'h0, 64'hDD, 64'hCC};
        do_write(32'h300, 8'd1, 2'b01, 4'd6, wd, 8'hFF, 4'b0000, 0, resp, bid);
        check("w_missing_last_resp", 64'(resp), 64'd2);
        $display("write addr=300 len=1 missing w_last resp=%0b", resp);

        wd = {64'h0, 64'hDEAD3, 64'hDEAD2, 64'hDEAD1};
        do_write(32'h100, 8'd2, 2'b11, 4'd7, wd, 8'hFF, 4'b0100, 0, resp, bid);
        check("w_burst11_resp", 64'(resp), 64'd2);
        $display("write addr=100 len=2 burst=11 resp=%0b", resp);

        wd = {64'h0, 64'h0, 64'h0, 64'h77};
        do_write(32'h0, 8'd0, 2'b01, 4'd1, wd, 8'hFF, 4'b0001, 4, resp, bid);
        check("w_bstall_resp", 64'(resp), 64'd0);
        check("w_bstall_bid",  64'(bid),  64'd1);
        $display("write addr=0 len=0 b_ready held low 4 cycles resp=%0b", resp);

        // Read table
        for (int v = 0; v < 11; v++) begin
            do_read(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, 4'(v), -1, 0, 64'h0, 1'b0);
            check($sformatf("v%0d_beats", v), 64'(got_n), 64'(int'(vecs[v].len) + 1));
            for (int i = 0; i < got_n; i++) begin
                check($sformatf("v%0d_b%0d_data", v, i), got_data[i], vecs[v].exp[i]);
                check($sformatf("v%0d_b%0d_resp", v, i), 64'(got_resp[i]), 64'(vecs[v].resp));
                check($sformatf("v%0d_b%0d_last", v, i), 64'(got_last[i]), 64'(i == int'(vecs[v].len)));
                check($sformatf("v%0d_b%0d_id", v, i), 64'(got_id[i]), 64'(v));
                check($sformatf("v%0d_b%0d_lat", v, i), 64'(got_lat[i]), 64'd1);
            end
            $display("read vec %0d addr=%0h len=%0d size=%0d burst=%0b beats=%0d",
                     v, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, got_n);
        end

        // Backpressure: r_ready low for 5 cycles on beat 1
        do_read(32'h100, 8'd3, 3'd3, 2'b01, 4'd9, 1, 5, 64'h22, 1'b0);
        check("bp_beats", 64'(got_n), 64'd4);
        for (int i = 0; i < got_n; i++) begin
            check($sformatf("bp_b%0d_data", i), got_data[i], 64'(8'h11 * (i + 1)));
            check($sformatf("bp_b%0d_last", i), 64'(got_last[i]), 64'(i == 3));
        end
        $display("read addr=100 len=3 with r_ready stall beats=%0d", got_n);

        // Partial strobe write
        wd = {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        do_write(32'h108, 8'd0, 2'b01, 4'd2, wd, 8'h0F, 4'b0001, 0, resp, bid);
        check("w_strb_resp", 64'(resp), 64'd0);
        do_read(32'h108, 8'd0, 3'd3, 2'b01, 4'd2, -1, 0, 64'h0, 1'b0);
        check("strb_read_data", got_data[0], 64'h0000_0000_FFFF_FFFF);
        $display("write addr=108 strb=0F then read data=%0h", got_data[0]);

        // Reset in the middle of a write burst
        @(negedge clk);
        aw_valid = 1'b1; aw_id = 4'd4; aw_addr = 32'h500; aw_len = 8'd3; aw_size = 3'd3; aw_burst = 2'b01;
        @(negedge clk);
        aw_valid = 1'b0;
        w_valid = 1'b1; w_data = 64'h99; w_strb = 8'hFF; w_last = 1'b0;
        @(negedge clk);
        check("mid_w_ready_before", 64'(w_ready), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_w_ready",  64'(w_ready),  64'd0);
        check("mid_rst_b_valid",  64'(b_valid),  64'd0);
        check("mid_rst_aw_ready", 64'(aw_ready), 64'd0);
        w_valid = 1'b0;
        $display("reset asserted mid write burst w_ready=%0b b_valid=%0b", w_ready, b_valid);
        @(negedge clk);
        rst_n = 1'b1;

        wd = {64'h0, 64'h0, 64'h0, 64'h55};
        do_write(32'h400, 8'd0, 2'b01, 4'd8, wd, 8'hFF, 4'b0001, 0, resp, bid);
        check("post_rst_w_resp", 64'(resp), 64'd0);
        check("post_rst_w_bid",  64'(bid),  64'd8);
        do_read(32'h400, 8'd0, 3'd3, 2'b01, 4'd8, -1, 0, 64'h0, 1'b0);
        check("post_rst_new_data", got_data[0], 64'h55);
        do_read(32'h110, 8'd1, 3'd3, 2'b01, 4'd8, -1, 0, 64'h0, 1'b0);
        check("post_rst_kept_0", got_data[0], 64'h33);
        check("post_rst_kept_1", got_data[1], 64'h44);
        $display("after reset: new word=%0h retained words=%0h,%0h", 64'h55, got_data[0], got_data[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
